// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR tap sequencer: FSM state encoding,
// FP32 constants and the bit positions inside the {invalid, overflow, underflow} flag vector.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHold
    } seq_state_e;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    localparam int unsigned FLAG_W         = 3;
    localparam int unsigned FLAG_INVALID   = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

endpackage

// File: rtl/fir_tap_ram.sv
// DEPTH x WIDTH register array with one synchronous write port and one combinational read
// port; all entries clear on reset. Used for both the delay line and the coefficient store.
module fir_tap_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller driving one FP32 MAC tap; holds delay line and coefficients.
// Define FIR_SEQ_FLAGS_EN to include the OR-accumulated exception flags on m_flags_o.
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_TAPS   = 16,
    parameter int unsigned DSP_LAT    = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [DATA_WIDTH-1:0]       s_data_i,
    input  logic                        coef_we_i,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr_i,
    input  logic [DATA_WIDTH-1:0]       coef_data_i,
    output logic                        coef_err_o,
    output logic [DATA_WIDTH-1:0]       dsp_x_o,
    output logic [DATA_WIDTH-1:0]       dsp_h_o,
    output logic                        dsp_fpopmode_bit_o,
    output logic                        dsp_rst_o,
    input  logic [DATA_WIDTH-1:0]       dsp_y_i,
    input  logic                        dsp_invalid_i,
    input  logic                        dsp_overflow_i,
    input  logic                        dsp_underflow_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [DATA_WIDTH-1:0]       m_data_o,
    output logic [FLAG_W-1:0]           m_flags_o
);

    localparam int unsigned AW = $clog2(NUM_TAPS);
    localparam int unsigned DW = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
    localparam logic [AW-1:0] K_LAST = AW'(NUM_TAPS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DSP_LAT - 1);

    seq_state_e            state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, base_q, base_d, k_q, k_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  ready_en_q, coef_err_q;
    logic                  accept, coef_wr;
    logic [AW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] buf_rdata, coef_rdata;

    // ready_en_q keeps s_ready_o low until the first edge after reset release
    assign s_ready_o = ready_en_q && (state_q == StIdle);
    assign accept    = s_valid_i && s_ready_o;
    assign coef_wr   = coef_we_i && (state_q == StIdle);
    assign rd_idx    = base_q - k_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        base_d   = base_q;
        k_d      = k_q;
        drain_d  = drain_q;
        m_data_d = m_data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StRun;
                    base_d   = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    k_d      = '0;
                end
            end
            StRun: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == D_LAST) begin
                    state_d  = StHold;
                    m_data_d = dsp_y_i;
                end
            end
            StHold: begin
                if (m_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            base_q     <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            m_data_q   <= '0;
            ready_en_q <= 1'b0;
            coef_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            base_q     <= base_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            m_data_q   <= m_data_d;
            ready_en_q <= 1'b1;
            coef_err_q <= coef_we_i && !coef_wr;
        end
    end

    assign dsp_x_o            = (state_q == StRun) ? buf_rdata : DATA_WIDTH'(FP_ZERO);
    assign dsp_h_o            = (state_q == StRun) ? coef_rdata : DATA_WIDTH'(FP_ZERO);
    assign dsp_fpopmode_bit_o = (state_q == StRun) && (k_q != '0);
    assign dsp_rst_o          = (state_q == StIdle);
    assign m_valid_o          = (state_q == StHold);
    assign m_data_o           = m_data_q;
    assign coef_err_o         = coef_err_q;

`ifdef FIR_SEQ_FLAGS_EN
    logic [FLAG_W-1:0] flags_q, flags_d, dsp_flags;
    logic              flag_win;

    // Tap k's product is on dsp_y_i DSP_LAT edges after it is issued
    assign flag_win = ((state_q == StRun) && (32'(k_q) >= DSP_LAT)) ||
                      ((state_q == StDrain) && (32'(drain_q) + NUM_TAPS >= DSP_LAT));

    always_comb begin
        dsp_flags                 = '0;
        dsp_flags[FLAG_INVALID]   = dsp_invalid_i;
        dsp_flags[FLAG_OVERFLOW]  = dsp_overflow_i;
        dsp_flags[FLAG_UNDERFLOW] = dsp_underflow_i;
        flags_d = flags_q;
        if (accept) begin
            flags_d = '0;
        end else if (flag_win) begin
            flags_d = flags_q | dsp_flags;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign m_flags_o = flags_q;
`else
    logic unused_flags;
    assign unused_flags = dsp_invalid_i ^ dsp_overflow_i ^ dsp_underflow_i;
    assign m_flags_o    = '0;
`endif

    fir_tap_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (NUM_TAPS)
    ) u_delay_line (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_data_i),
        .raddr_i (rd_idx),
        .rdata_o (buf_rdata)
    );

    fir_tap_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (NUM_TAPS)
    ) u_coef_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (coef_wr),
        .waddr_i (coef_addr_i),
        .wdata_i (coef_data_i),
        .raddr_i (k_q),
        .rdata_o (coef_rdata)
    );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench: behavioural FP32 MAC tap model plus a convolution reference model.
module tb_fir_tap_sequencer;

    localparam int NUM_TAPS = 16;
    localparam int DSP_LAT  = 4;
    localparam int LAT_EXP  = NUM_TAPS + DSP_LAT + 1;
`ifdef FIR_SEQ_FLAGS_EN
    localparam bit [2:0] OVF_FLAGS = 3'b010;
`else
    localparam bit [2:0] OVF_FLAGS = 3'b000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [31:0] coef_data = '0;
    logic        coef_err;
    logic [31:0] dsp_x, dsp_h;
    logic        dsp_op, dsp_rst;
    bit   [31:0] dsp_y;
    bit          dsp_inv, dsp_ovf, dsp_unf;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [2:0]  m_flags;

    int checks = 0;
    int errors = 0;

    bit [31:0] mcoef [NUM_TAPS];
    bit [31:0] hist [$];

    always #5 clk = ~clk;

    fir_tap_sequencer #(
        .DATA_WIDTH (32),
        .NUM_TAPS   (NUM_TAPS),
        .DSP_LAT    (DSP_LAT)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .s_valid_i          (s_valid),
        .s_ready_o          (s_ready),
        .s_data_i           (s_data),
        .coef_we_i          (coef_we),
        .coef_addr_i        (coef_addr),
        .coef_data_i        (coef_data),
        .coef_err_o         (coef_err),
        .dsp_x_o            (dsp_x),
        .dsp_h_o            (dsp_h),
        .dsp_fpopmode_bit_o (dsp_op),
        .dsp_rst_o          (dsp_rst),
        .dsp_y_i            (dsp_y),
        .dsp_invalid_i      (dsp_inv),
        .dsp_overflow_i     (dsp_ovf),
        .dsp_underflow_i    (dsp_unf),
        .m_valid_o          (m_valid),
        .m_ready_i          (m_ready),
        .m_data_o           (m_data),
        .m_flags_o          (m_flags)
    );

    function automatic real f2r(input bit [31:0] f);
        bit [63:0] d;
        if (f[30:23] == 8'd0)       d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else                        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic bit [31:0] r2f(input real r, output bit ovf, output bit unf);
        bit [63:0] d;
        int        e;
        d   = $realtobits(r);
        e   = int'(d[62:52]) - 896;
        ovf = 1'b0;
        unf = 1'b0;
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, |d[51:0], d[50:29]};
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        if (e >= 255) begin ovf = 1'b1; return {d[63], 8'hFF, 23'd0}; end
        if (e <= 0) begin unf = 1'b1; return {d[63], 31'd0}; end
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic bit [31:0] int2f(input int v);
        bit o, u;
        return r2f(real'(v), o, u);
    endfunction

    // Expected output: direct convolution over everything accepted since reset
    function automatic bit [31:0] ref_out();
        real acc = 0.0;
        bit  o, u;
        int  n = hist.size() - 1;
        for (int k = 0; k < NUM_TAPS; k++)
            if (n - k >= 0) acc += f2r(mcoef[k]) * f2r(hist[n - k]);
        return r2f(acc, o, u);
    endfunction

    // Tap model: operands captured at edge e reach dsp_y after edge e+DSP_LAT-1
    bit [31:0] p_x [DSP_LAT-1];
    bit [31:0] p_h [DSP_LAT-1];
    bit        p_op [DSP_LAT-1];
    bit        p_rst [DSP_LAT-1];

    always @(posedge clk) begin : dsp_model
        real       prod, res;
        bit        o, u;
        bit [31:0] yb;
        if (p_rst[DSP_LAT-2]) begin
            dsp_y   <= '0;
            dsp_inv <= 1'b0;
            dsp_ovf <= 1'b0;
            dsp_unf <= 1'b0;
        end else begin
            prod = f2r(p_x[DSP_LAT-2]) * f2r(p_h[DSP_LAT-2]);
            res  = p_op[DSP_LAT-2] ? prod + f2r(dsp_y) : prod;
            yb   = r2f(res, o, u);
            dsp_y   <= yb;
            dsp_ovf <= o;
            dsp_unf <= u;
            dsp_inv <= (yb[30:23] == 8'hFF) && (yb[22:0] != 0);
        end
        for (int i = DSP_LAT - 2; i > 0; i--) begin
            p_x[i]   <= p_x[i-1];
            p_h[i]   <= p_h[i-1];
            p_op[i]  <= p_op[i-1];
            p_rst[i] <= p_rst[i-1];
        end
        p_x[0]   <= dsp_x;
        p_h[0]   <= dsp_h;
        p_op[0]  <= dsp_op;
        p_rst[0] <= dsp_rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        hist.delete();
        foreach (mcoef[i]) mcoef[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic write_coef(input int a, input bit [31:0] v);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = v;
        @(negedge clk);
        coef_we   = 1'b0;
        mcoef[a]  = v;
    endtask

    task automatic accept_sample(input bit [31:0] d, output int waited);
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: s_ready=%b required 1", s_ready);
        end else begin
            hist.push_back(d);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic collect(input int start, input int delay, output bit [31:0] y,
                           output bit [2:0] f, output int lat);
        lat = start;
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout: m_valid=%b required 1", m_valid);
        end
        repeat (delay) @(negedge clk);
        y = m_data;
        f = m_flags;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        logic [103:0] obs, req;
        obs = {s_ready, dsp_rst, m_valid, m_data, m_flags, coef_err, dsp_x, dsp_h, dsp_op};
        req = {1'b0, 1'b1, 102'd0};
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s: outputs=%h required %h", name, obs, req);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready, dsp_rst, m_valid} !== 3'b110) begin
            errors++;
            $display("FAIL ready_after_release: got %b required 110", {s_ready, dsp_rst, m_valid});
        end
    endtask

    task automatic test_ones();
        bit [31:0] y, exp;
        bit [2:0]  f;
        int        lat, w;
        do_reset();
        for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 32'h3F80_0000);
        checks++;
        if (coef_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_write_err: coef_err=%b required 0", coef_err);
        end
        for (int i = 0; i < 20; i++) begin
            accept_sample(32'h3F80_0000, w);
            collect(1, 0, y, f, lat);
            exp = ref_out();
            checks++;
            if (y !== exp || f !== 3'b000) begin
                errors++;
                $display("FAIL ones[%0d]: data=%h flags=%b required %h 000", i, y, f, exp);
            end
            if (i == 0) begin
                checks++;
                if (lat != LAT_EXP) begin
                    errors++;
                    $display("FAIL latency: %0d required %0d", lat, LAT_EXP);
                end
            end
        end
        checks++;
        if (y !== 32'h4180_0000) begin
            errors++;
            $display("FAIL ones_saturate: data=%h required 41800000", y);
        end
    endtask

    task automatic run_impulse(input string name);
        bit [31:0] y, exp;
        bit [2:0]  f;
        int        lat, w;
        for (int k = 0; k < NUM_TAPS; k++) write_coef(k, int2f(k + 1));
        for (int i = 0; i <= NUM_TAPS; i++) begin
            accept_sample(i == 0 ? 32'h3F80_0000 : 32'h0, w);
            collect(1, 0, y, f, lat);
            exp = ref_out();
            checks++;
            if (y !== exp) begin
                errors++;
                $display("FAIL %s[%0d]: data=%h required %h", name, i, y, exp);
            end
        end
    endtask

    task automatic test_impulse();
        bit [31:0] y, exp, ex;
        bit [2:0]  f;
        int        lat, w, n;
        do_reset();
        for (int k = 0; k < NUM_TAPS; k++) write_coef(k, int2f(k + 1));
        for (int k = 0; k < 3; k++) begin
            accept_sample(int2f(k + 2), w);
            collect(1, 0, y, f, lat);
        end
        // Per-cycle operand/opmode sequence of one pass, with wrapped delay-line reads
        accept_sample(int2f(5), w);
        n = hist.size() - 1;
        for (int c = 0; c < NUM_TAPS; c++) begin
            ex = (n - c >= 0) ? hist[n - c] : 32'h0;
            checks++;
            if ({dsp_x, dsp_h, dsp_op, dsp_rst} !== {ex, mcoef[c], c != 0, 1'b0}) begin
                errors++;
                $display("FAIL tap_seq[%0d]: x=%h h=%h op=%b rst=%b required %h %h %b 0",
                         c, dsp_x, dsp_h, dsp_op, dsp_rst, ex, mcoef[c], c != 0);
            end
            @(negedge clk);
        end
        checks++;
        if ({dsp_x, dsp_h, dsp_op, dsp_rst} !== 66'd0) begin
            errors++;
            $display("FAIL drain_outputs: x=%h h=%h op=%b rst=%b required 0", dsp_x, dsp_h,
                     dsp_op, dsp_rst);
        end
        collect(NUM_TAPS + 1, 0, y, f, lat);
        exp = ref_out();
        checks++;
        if (y !== exp || lat != LAT_EXP) begin
            errors++;
            $display("FAIL tap_seq_result: data=%h lat=%0d required %h %0d", y, lat, exp, LAT_EXP);
        end
        do_reset();
        run_impulse("impulse");
    endtask

    task automatic test_random();
        bit [31:0] y, exp;
        bit [2:0]  f;
        int        lat, w;
        do_reset();
        for (int k = 0; k < NUM_TAPS; k++) write_coef(k, int2f(int'($urandom_range(0, 14)) - 7));
        for (int i = 0; i < 24; i++) begin
            accept_sample(int2f(int'($urandom_range(0, 14)) - 7), w);
            collect(1, int'($urandom_range(0, 3)), y, f, lat);
            exp = ref_out();
            checks++;
            if (y !== exp || f !== 3'b000 || lat != LAT_EXP) begin
                errors++;
                $display("FAIL random[%0d]: data=%h flags=%b lat=%0d required %h 000 %0d",
                         i, y, f, lat, exp, LAT_EXP);
            end
        end
    endtask

    task automatic test_backpressure();
        bit [31:0] y, exp;
        bit [2:0]  f;
        int        lat, w;
        accept_sample(int2f(int'($urandom_range(1, 7))), w);
        exp = ref_out();
        lat = 1;
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({m_valid, s_ready, m_data, m_flags} !== {1'b1, 1'b0, exp, 3'b000}) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b ready=%b data=%h flags=%b required 1 0 %h 000",
                         c, m_valid, s_ready, m_data, m_flags, exp);
            end
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if ({m_valid, s_ready} !== 2'b01) begin
            errors++;
            $display("FAIL release: valid=%b ready=%b required 0 1", m_valid, s_ready);
        end
        accept_sample(int2f(int'($urandom_range(1, 7))), w);
        collect(1, 0, y, f, lat);
        exp = ref_out();
        checks++;
        if (w != 0 || y !== exp) begin
            errors++;
            $display("FAIL back_to_back: wait=%0d data=%h required 0 %h", w, y, exp);
        end
    endtask

    task automatic test_dropped_write();
        bit [31:0] y, exp;
        bit [2:0]  f;
        int        lat, w;
        accept_sample(int2f(int'($urandom_range(1, 7))), w);
        repeat (2) @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = int2f(11);
        @(negedge clk);
        coef_we = 1'b0;
        checks++;
        if (coef_err !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse: coef_err=%b required 1", coef_err);
        end
        @(negedge clk);
        checks++;
        if (coef_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_single: coef_err=%b required 0", coef_err);
        end
        collect(5, 0, y, f, lat);
        exp = ref_out();
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL drop_result: data=%h required %h", y, exp);
        end
        // Write and accept on the same IDLE edge: the new coefficient must be used
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = int2f(9);
        mcoef[0]  = int2f(9);
        accept_sample(int2f(int'($urandom_range(1, 7))), w);
        coef_we = 1'b0;
        checks++;
        if (coef_err !== 1'b0 || w != 0) begin
            errors++;
            $display("FAIL same_cycle_err: coef_err=%b wait=%0d required 0 0", coef_err, w);
        end
        collect(1, 0, y, f, lat);
        exp = ref_out();
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL same_cycle_result: data=%h required %h", y, exp);
        end
    endtask

    task automatic test_overflow();
        bit [31:0] y, exp;
        bit [2:0]  f;
        int        lat, w;
        do_reset();
        write_coef(0, 32'h7F00_0000);
        accept_sample(32'h7F00_0000, w);
        collect(1, 0, y, f, lat);
        exp = ref_out();
        checks++;
        if (y !== exp || f !== OVF_FLAGS) begin
            errors++;
            $display("FAIL overflow: data=%h flags=%b required %h %b", y, f, exp, OVF_FLAGS);
        end
    endtask

    task automatic test_reset_mid_run();
        bit [31:0] y;
        bit [2:0]  f;
        int        lat, w;
        do_reset();
        for (int k = 0; k < NUM_TAPS; k++) write_coef(k, int2f(k + 1));
        accept_sample(32'h3F80_0000, w);
        collect(1, 0, y, f, lat);
        accept_sample(32'h3F80_0000, w);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_run_reset");
        hist.delete();
        foreach (mcoef[i]) mcoef[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_impulse("post_reset_impulse");
    endtask

    initial begin
        test_reset();
        test_ones();
        test_impulse();
        test_random();
        test_backpressure();
        test_dropped_write();
        test_overflow();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
